// File: rtl/lsu_pkg.sv
// Shared encodings, widths and the alignment rule for the load/store unit.
package lsu_pkg;

  localparam int ADDR_W  = 13;
  localparam int WADDR_W = 11;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Reserved size, or a halfword/word whose low address bits are not aligned.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      SIZE_RSVD: bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] mem_word,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [DATA_W-1:0] shifted;
  logic [3:0]        lane_sel;

  assign shifted = mem_word >> {offset, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   load_data = mem_word;
    endcase
  end

  // Byte stores replicate wdata[7:0], half stores wdata[15:0]; unselected lanes keep memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src_byte;

      always_comb begin
        lane_sel[gi] = 1'b1;
        src_byte     = store_data[8*gi +: 8];
        case (size)
          SIZE_BYTE: begin
            lane_sel[gi] = (offset == 2'(gi));
            src_byte     = store_data[7:0];
          end
          SIZE_HALF: begin
            lane_sel[gi] = (offset[1] == 1'((gi >> 1) & 1));
            src_byte     = store_data[8*(gi % 2) +: 8];
          end
          default: begin
            lane_sel[gi] = 1'b1;
            src_byte     = store_data[8*gi +: 8];
          end
        endcase
      end

      assign merge_data[8*gi +: 8] = lane_sel[gi] ? src_byte : mem_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err,
  output logic [WADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0]  mem_in_data,
  output logic               mem_write,
  output logic               mem_read,
  input  logic [DATA_W-1:0]  mem_out_data
);

  state_e            state_reg;
  logic              write_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              err_reg;

  logic              req_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  assign req_err = access_error(req_size, req_addr[1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      write_reg  <= 1'b0;
      size_reg   <= 2'b00;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            write_reg  <= req_write;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            err_reg    <= req_err;
            if (req_err)
              state_reg <= ST_RESP;
            else if (req_write && req_size == SIZE_WORD)
              state_reg <= ST_WRITE;
            else
              state_reg <= ST_READ;
          end
        end
        // Sub-word stores pass through READ to fetch the word they merge into.
        ST_READ:  state_reg <= write_reg ? ST_WRITE : ST_RESP;
        ST_WRITE: state_reg <= ST_RESP;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .mem_word   (mem_out_data),
    .store_data (wdata_reg),
    .size       (size_reg),
    .offset     (addr_reg[1:0]),
    .sign_ext   (signed_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Everything below is decoded from the state so reset takes effect without a clock.
  assign req_ready   = (state_reg == ST_IDLE);
  assign mem_read    = (state_reg == ST_READ);
  assign mem_write   = (state_reg == ST_WRITE);
  assign resp_valid  = (state_reg == ST_RESP);
  assign resp_err    = resp_valid & err_reg;
  assign resp_rdata  = (resp_valid && !err_reg && !write_reg) ? load_data : '0;
  assign mem_address = (mem_read || mem_write) ? addr_reg[ADDR_W-1:2] : '0;
  assign mem_in_data = mem_write ? merge_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [10:0] mem_address;
  logic [31:0] mem_in_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_out_data;

  load_store_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_out_data (mem_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem_out_data = 32'h0;
  end
  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_in_data;
    if (mem_read)  mem_out_data <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic [10:0] maddr;
    logic [31:0] wword;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: strobes against the in-flight request, responses against the queue head.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) begin
          check("strobe_without_request", {30'h0, mem_read, mem_write}, 32'h0);
        end else begin
          if (exp_q[0].err) check("strobe_on_error", {30'h0, mem_read, mem_write}, 32'h0);
          check("mem_address", {21'h0, mem_address}, {21'h0, exp_q[0].maddr});
          if (mem_write) check("mem_in_data", mem_in_data, exp_q[0].wword);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("resp cyc=%0d rdata=%h err=%0b", cyc, resp_rdata, resp_err);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          check("resp_cycle", cyc, e.cyc);
          check("ready_in_resp", {31'h0, req_ready}, 32'h0);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [12:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input logic [31:0] exp_wword, input logic hold, input logic push,
                       output int waited);
    exp_t e;
    waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      waited++;
      @(negedge clock);
    end
    if (!req_ready) check("ready_timeout", 32'h0, 32'h1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      e.maddr = addr[12:2];
      e.wword = exp_wword;
      exp_q.push_back(e);
    end
    @(posedge clock);
    if (!hold) begin
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("resp_timeout", exp_q.size(), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   {31'h0, req_ready}, 32'h1);
    check({tag, "_resp_valid"},  {31'h0, resp_valid}, 32'h0);
    check({tag, "_resp_err"},    {31'h0, resp_err}, 32'h0);
    check({tag, "_mem_read"},    {31'h0, mem_read}, 32'h0);
    check({tag, "_mem_write"},   {31'h0, mem_write}, 32'h0);
    check({tag, "_resp_rdata"},  resp_rdata, 32'h0);
    check({tag, "_mem_address"}, {21'h0, mem_address}, 32'h0);
    check({tag, "_mem_in_data"}, mem_in_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int w1;
    int w2;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 13'h0;
    req_wdata  = 32'h0;
    #3;
    check_reset_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // wr sz sg addr wdata exp_rdata err lat exp_wword hold push
    issue(1, 2'b10, 0, 13'h010, 32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF, 0, 1, w);
    issue(0, 2'b10, 0, 13'h010, 32'h0,        32'hDEADBEEF, 0, 2, 32'h0,        0, 1, w);
    issue(1, 2'b00, 0, 13'h012, 32'h00000055, 32'h0,        0, 3, 32'hDE55BEEF, 0, 1, w);
    issue(0, 2'b10, 0, 13'h010, 32'h0,        32'hDE55BEEF, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b00, 1, 13'h013, 32'h0,        32'hFFFFFFDE, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b00, 0, 13'h013, 32'h0,        32'h000000DE, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b01, 1, 13'h012, 32'h0,        32'hFFFFDE55, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b01, 0, 13'h011, 32'h0,        32'h0,        1, 1, 32'h0,        0, 1, w);
    issue(0, 2'b10, 0, 13'h012, 32'h0,        32'h0,        1, 1, 32'h0,        0, 1, w);
    issue(0, 2'b11, 0, 13'h010, 32'h0,        32'h0,        1, 1, 32'h0,        0, 1, w);
    issue(1, 2'b01, 0, 13'h011, 32'h0000BEEF, 32'h0,        1, 1, 32'h0,        0, 1, w);
    issue(1, 2'b01, 0, 13'h010, 32'h1234ABCD, 32'h0,        0, 3, 32'hDE55ABCD, 0, 1, w);
    issue(0, 2'b01, 0, 13'h010, 32'h0,        32'h0000ABCD, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b00, 0, 13'h011, 32'h0,        32'h000000AB, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b00, 1, 13'h011, 32'h0,        32'hFFFFFFAB, 0, 2, 32'h0,        0, 1, w);
    issue(0, 2'b00, 1, 13'h010, 32'h0,        32'hFFFFFFCD, 0, 2, 32'h0,        0, 1, w);
    issue(1, 2'b10, 0, 13'h1FFC, 32'hCAFEF00D, 32'h0,       0, 2, 32'hCAFEF00D, 0, 1, w);
    issue(0, 2'b00, 0, 13'h1FFF, 32'h0,       32'h000000CA, 0, 2, 32'h0,        0, 1, w);
    issue(1, 2'b00, 0, 13'h1FFF, 32'h00000011, 32'h0,       0, 3, 32'h11FEF00D, 0, 1, w);
    drain();

    // Reset lands while the word store sits in WRITE; the store must be lost.
    issue(1, 2'b10, 0, 13'h020, 32'h12345678, 32'h0, 0, 2, 32'h12345678, 0, 0, w);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("midwrite");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    issue(0, 2'b10, 0, 13'h020, 32'h0, 32'h00000000, 0, 2, 32'h0, 0, 1, w);
    drain();

    // Three back-to-back loads with req_valid held high.
    issue(0, 2'b10, 0, 13'h010, 32'h0, 32'hDE55ABCD, 0, 2, 32'h0, 1, 1, w);
    issue(0, 2'b10, 0, 13'h1FFC, 32'h0, 32'h11FEF00D, 0, 2, 32'h0, 1, 1, w1);
    issue(0, 2'b10, 0, 13'h020, 32'h0, 32'h00000000, 0, 2, 32'h0, 1, 1, w2);
    check("b2b_wait_2", w1, 32'd2);
    check("b2b_wait_3", w2, 32'd2);
    @(negedge clock);
    req_valid = 1'b0;
    drain();

    repeat (4) @(negedge clock);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clock  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: req_valid  in  1  pipeline requests a memory access.
REQ-004 SHALL have: req_ready  out  1  unit idle, accepts request this cycle.
REQ-005 SHALL have: req_write  in  1  1 = store, 0 = load.
REQ-006 SHALL have: req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have: req_signed  in  1  sign-extend sub-word loads.
REQ-008 SHALL have: req_addr  in  13  byte address.
REQ-009 SHALL have: req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have: resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have: resp_rdata  out  32  load result; 0 for stores and errors.
REQ-012 SHALL have: resp_err  out  1  misaligned or reserved-size access, valid with resp_valid.
REQ-013 SHALL have: mem_address  out  11  word address to data memory.
REQ-014 SHALL have: mem_in_data  out  32  write word to data memory.
REQ-015 SHALL have: mem_write / mem_read  out  1 each  data memory strobes.
REQ-016 SHALL have: mem_out_data  in  32  data memory read word; valid after the rising edge on which mem_read was high, held until the next read.

Function
REQ-017 States SHALL be IDLE, READ, WRITE, RESP; req_ready = (state == IDLE).
REQ-018 In IDLE with req_valid, the unit SHALL latch write, size, signed, addr, wdata on the rising edge; req_valid outside IDLE is ignored.
REQ-019 Error (word with addr[1:0] != 0, half with addr[0] = 1, size 11) SHALL go IDLE->RESP with no mem strobe, resp_err = 1, resp_rdata = 0.
REQ-020 Load SHALL go IDLE->READ->RESP; mem_read = 1 only in READ; resp_valid in the 2nd cycle after acceptance.
REQ-021 Word store SHALL go IDLE->WRITE->RESP; mem_write = 1 only in WRITE; mem_in_data = wdata.
REQ-022 Byte/half store SHALL go IDLE->READ->WRITE->RESP (read-modify-write); in WRITE, mem_in_data = mem_out_data with the addressed lanes replaced by wdata[7:0] / wdata[15:0]; other lanes unchanged.
REQ-023 Lanes are little-endian: byte n = bits 8n+7:8n; half at addr[1] = 1 is bits 31:16.
REQ-024 Load extraction: selected lane right-justified, zero-extended if req_signed = 0, sign-extended from lane MSB otherwise; word loads pass through.
REQ-025 mem_address SHALL equal latched addr[12:2] in READ and WRITE; strobes SHALL be decoded from state only (never high in IDLE or RESP).
REQ-026 RESP SHALL last exactly one cycle, then IDLE; back-to-back requests accepted from the following cycle.
REQ-027 Address wrap: addr 13'h1FFF maps to mem_address 11'h7FF; no carry beyond it.

Reset
REQ-028 reset_n low SHALL immediately force IDLE; req_ready = 1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_address, mem_in_data = 0.
REQ-029 Reset asserted in WRITE before the falling edge SHALL drop mem_write so the write is aborted; in-flight requests are discarded, no response.

Structure
REQ-030 Shared package lsu_pkg SHALL hold size encodings, state encoding and the 13/11/32 width constants.
REQ-031 Lane extract/merge SHALL be one combinational sub-module lsu_lane_align, used for both load extraction and store merge.

Verification
REQ-032 Word store 0xDEADBEEF to addr 0x010, then word load addr 0x010 -> mem_address 0x004, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-033 After REQ-032, byte store 0x55 to addr 0x012, then word load -> 0xDE55BEEF; byte load signed addr 0x013 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-034 Half load signed addr 0x012 after REQ-033 -> 0xFFFFDE55; half load addr 0x011 -> resp_err 1, resp_rdata 0, mem_read never high.
REQ-035 reset_n low during WRITE of word store 0x12345678 to addr 0x020 (before falling edge) -> word load of 0x020 returns prior value 0x00000000; req_ready 1 during reset.
REQ-036 req_valid held high for three back-to-back word loads -> exactly three resp_valid pulses, each 2 cycles after its acceptance, req_ready low in READ and RESP.
